// File: rtl/wm8731_pkg.sv
// rtl/wm8731_pkg.sv - shared types, constants and parameter check for the WM8731 DAC serializer
//
// Contents:
//   state_t          frame sequencer states (IDLE, SYNC, SHIFT)
//   FRAME_TICKS_48M  en48m ticks available per 32 kHz frame
//   frame_fits()     true when a full (2*WIDTH+1)-BCLK frame fits in one 32 kHz period
package wm8731_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  localparam int FRAME_TICKS_48M = 1500;

  // One sync BCLK period plus 2*width data periods, each 2*half_bclk ticks long.
  function automatic bit frame_fits(input int width, input int half_bclk);
    return (2 * half_bclk * (2 * width + 1)) < FRAME_TICKS_48M;
  endfunction

endpackage

// File: rtl/en_divider.sv
// rtl/en_divider.sv - clock-enable divider emitting one tick every DIV input enables
//
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   en       in   input enable to be counted
//   clr      in   synchronous clear; holds the count at 0 and suppresses tick
//   tick     out  single-cycle pulse on the enable that completes each group of DIV
module en_divider #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Combinational so the consumer acts in the same cycle as the wrapping enable.
  assign tick = en && !clr && (cnt == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/wm8731_dac_serializer.sv
// rtl/wm8731_dac_serializer.sv - mono sample to WM8731 DSP mode A (LRP=0) DAC serializer, FPGA master
//
// Ports:
//   clk        in   system clock (240 MHz)
//   reset_n    in   asynchronous active-low reset
//   en48m      in   48 MHz clock enable, single-cycle pulse
//   en32k      in   frame strobe, coincident with an en48m pulse
//   audio_dat  in   signed sample, captured only on en32k while idle
//   mclk       out  free-running codec master clock
//   bclk       out  bit clock, idle low between frames
//   dac_lr_ck  out  frame sync pulse, one BCLK period wide
//   dac_dat    out  serial data, MSB first, left slot then right slot
//   busy       out  high while a frame is in progress
//   overrun    out  sticky flag: en32k arrived while busy
module wm8731_dac_serializer
  import wm8731_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int HALF_BCLK = 20,
  parameter int MCLK_DIV  = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en48m,
  input  logic             en32k,
  input  logic [WIDTH-1:0] audio_dat,
  output logic             mclk,
  output logic             bclk,
  output logic             dac_lr_ck,
  output logic             dac_dat,
  output logic             busy,
  output logic             overrun
);

  localparam int  SW        = 2 * WIDTH;
  localparam int  BW        = $clog2(SW);
  localparam logic [BW-1:0] LAST_BIT = BW'(SW - 1);
  localparam bit  PARAMS_OK = frame_fits(WIDTH, HALF_BCLK);

  state_t          state;
  logic [SW-1:0]   sreg;
  logic [BW-1:0]   bit_cnt;
  logic            mclk_tick;
  logic            half_tick;

  always_ff @(posedge clk) begin
    assert (PARAMS_OK)
      else $error("wm8731_dac_serializer: WIDTH/HALF_BCLK frame exceeds the 32 kHz period");
  end

  en_divider #(.DIV(MCLK_DIV)) u_mclk_div (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en48m),
    .clr     (1'b0),
    .tick    (mclk_tick)
  );

  // Held cleared while idle so every frame starts with a full first half-period.
  en_divider #(.DIV(HALF_BCLK)) u_bclk_div (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en48m),
    .clr     (state == IDLE),
    .tick    (half_tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mclk <= 1'b0;
    end else if (mclk_tick) begin
      mclk <= ~mclk;
    end
  end

  // A half tick while bclk is high is a falling edge: the only point where
  // dac_dat changes, keeping it stable across every rising edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      sreg      <= '0;
      bit_cnt   <= '0;
      bclk      <= 1'b0;
      dac_lr_ck <= 1'b0;
      dac_dat   <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      // Strobe outside IDLE (including the final falling-edge cycle) is dropped.
      if (en32k && state != IDLE) begin
        overrun <= 1'b1;
      end

      case (state)
        IDLE: begin
          bclk <= 1'b0;
          if (en32k) begin
            sreg      <= {audio_dat, audio_dat};
            dac_lr_ck <= 1'b1;
            busy      <= 1'b1;
            state     <= SYNC;
          end
        end

        SYNC: begin
          if (half_tick) begin
            bclk <= ~bclk;
            if (bclk) begin
              dac_lr_ck <= 1'b0;
              dac_dat   <= sreg[SW-1];
              bit_cnt   <= '0;
              state     <= SHIFT;
            end
          end
        end

        SHIFT: begin
          if (half_tick) begin
            bclk <= ~bclk;
            if (bclk) begin
              if (bit_cnt == LAST_BIT) begin
                dac_dat <= 1'b0;
                busy    <= 1'b0;
                state   <= IDLE;
              end else begin
                sreg    <= {sreg[SW-2:0], 1'b0};
                dac_dat <= sreg[SW-2];
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/wm8731_dac_serializer.md
Name: wm8731_dac_serializer

Overview:
- Serializes one 16-bit mono audio sample per 32 kHz frame into the WM8731 DAC interface in DSP mode A (LRP=0).
- Sample is duplicated to the left and right slots.
- FPGA is master: block generates BCLK, DACLRCK pulse, DACDAT and a free-running MCLK.
- Sits between the audio source mux (radio_core demodulator / test tone) and the codec pins, alongside the I2C configuration logic.

Parameters:
- WIDTH, 16, audio sample width in bits; frame carries 2*WIDTH data bits.
- HALF_BCLK, 20, en48m ticks per BCLK half-period (BCLK = 1.2 MHz).
- MCLK_DIV, 2, en48m ticks per MCLK half-period (MCLK = 12 MHz).

Ports:
- clk  in  1  system clock, 240 MHz.
- reset_n  in  1  asynchronous active-low reset.
- en48m  in  1  48 MHz clock enable, single-cycle pulse.
- en32k  in  1  frame strobe, single-cycle pulse, coincident with an en48m pulse.
- audio_dat  in  WIDTH  signed two's-complement sample, sampled only on en32k.
- mclk  out  1  codec master clock.
- bclk  out  1  bit clock.
- dac_lr_ck  out  1  frame sync pulse.
- dac_dat  out  1  serial data, MSB first.
- busy  out  1  high while a frame is being shifted.
- overrun  out  1  sticky: en32k arrived while busy.

Behaviour:
- Reset (async assert, sync release): mclk=0, bclk=0, dac_lr_ck=0, dac_dat=0, busy=0, overrun=0, state IDLE, all counters 0.
- All state advances only on clk cycles with en48m=1, except en32k capture, which is qualified by en48m by construction.
- MCLK: free-running; toggles every MCLK_DIV en48m ticks; independent of frame state; starts after reset release.
- Half-tick counter: counts en48m 0..HALF_BCLK-1. On wrap, bclk toggles. Counter is held at 0 and bclk held at 0 in IDLE.
- States: IDLE, SYNC, SHIFT.
- IDLE + en32k:
  - shift register <= {audio_dat, audio_dat} (2*WIDTH bits).
  - dac_lr_ck <= 1, busy <= 1, state <= SYNC, in the same cycle.
- SYNC:
  - one full BCLK period (rise after HALF_BCLK ticks, fall after 2*HALF_BCLK ticks).
  - On that falling edge: dac_lr_ck <= 0, dac_dat <= shift MSB, bit counter <= 0, state <= SHIFT.
  - Codec therefore sees the MSB on the 2nd BCLK rising edge after the LRC rise.
- SHIFT:
  - dac_dat changes only on BCLK falling edges; stable across each rising edge.
  - Each falling edge: shift left by one, dac_dat <= new MSB, bit counter increments.
  - On the falling edge ending bit 2*WIDTH-1: dac_dat <= 0, busy <= 0, bclk stays 0, state <= IDLE.
- Frame length: (2*WIDTH+1) BCLK periods = 66*HALF_BCLK = 1320 en48m ticks < 1500 ticks per 32 kHz frame. Legal parameter set requires 2*HALF_BCLK*(2*WIDTH+1) < 1500.
- en32k while busy: sample dropped, frame in progress unaffected, overrun <= 1. overrun is cleared only by reset.
- en32k in the same cycle busy falls (final falling edge): treated as busy → overrun; not expected with legal parameters.
- Reset mid-frame: all outputs return to reset values immediately (asynchronously); no partial frame resumes.
- Widths: bit counter is $clog2(2*WIDTH) bits; half-tick counter is $clog2(HALF_BCLK) bits; no arithmetic on sample data.

Decomposition:
- Package wm8731_pkg:
  - state enum (IDLE, SYNC, SHIFT).
  - FRAME_TICKS_48M=1500 constant.
  - Function checking the legal HALF_BCLK/WIDTH combination; the block elaborates an assertion from it.
- Sub-module en_divider (parameter DIV): counts an input enable and emits a single-cycle tick every DIV enables, with a synchronous clear. Two instances:
  - MCLK toggle, never cleared.
  - BCLK half-tick, cleared in IDLE.

Test Plan:
- Reset release, no en32k for 1000 en48m → mclk period exactly 4 en48m ticks (20 clk); bclk=dac_lr_ck=dac_dat=busy=0 throughout.
- en32k with audio_dat=16'hA5C3 → dac_lr_ck high for exactly 40 en48m; then 32 bits A5C3A5C3 MSB first, each sampled on bclk rising edge; busy low after 1320 en48m; dac_dat=0 afterwards.
- audio_dat=16'h8000, then 16'h7FFF in consecutive frames 1500 ticks apart → bit patterns 8000_8000 then 7FFF_7FFF; no overrun.
- Second en32k 500 ticks after first → first frame completes unchanged; second sample ignored; overrun=1 and stays 1 through subsequent valid frames.
- reset_n asserted mid-SHIFT at bit 10 → all outputs 0 in the same cycle, asynchronously. After release, the next en32k yields a clean full frame.
- audio_dat changes every clk while busy → serialized bits equal the value present at the en32k cycle only.
